// File: rtl/burst_mem_responder.sv
// Line-addressed memory responder: accepts one 256-bit line read or write and
// answers with four consecutive 64-bit beats after a programmable latency.
module burst_mem_responder #(
    parameter int IDX_W   = 8,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o,
    output logic        protocol_err_o
);

    localparam int         DEPTH  = 4 * (2 ** IDX_W);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RBURST,
        WBURST,
        TURN
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [1:0]         beat_reg, beat_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               op_wr_reg, op_wr_next;
    logic               err_reg, err_next;
    logic               resp_reg, resp_next;
    logic [63:0]        burst_reg, burst_next;
    logic               req_lost;

    // One 64-bit word per beat; a line occupies four consecutive words.
    logic [63:0] mem [0:DEPTH-1];

    // Address bits below the line offset and above the index are don't-care.
    logic unused_addr;
    assign unused_addr = ^{address_i[31:5+IDX_W], address_i[4:0]};

    // The latched request must stay up for the whole wait phase.
    assign req_lost = op_wr_reg ? !write_i : !read_i;

    // Next-state, counters and next registered outputs.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        beat_next  = beat_reg;
        idx_next   = idx_reg;
        op_wr_next = op_wr_reg;
        err_next   = err_reg;
        resp_next  = 1'b0;
        burst_next = 64'd0;
        case (state_reg)
            IDLE: begin
                if (read_i || write_i) begin
                    idx_next   = address_i[5+IDX_W-1:5];
                    op_wr_next = write_i;
                    cnt_next   = LAT_M1;
                    state_next = WAIT;
                    if (read_i && write_i) begin
                        err_next = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (req_lost) begin
                    state_next = TURN;
                    err_next   = 1'b1;
                end else if (cnt_reg == 4'd0) begin
                    state_next = op_wr_reg ? WBURST : RBURST;
                    beat_next  = 2'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RBURST, WBURST: begin
                if (beat_reg == 2'd3) begin
                    state_next = TURN;
                end else begin
                    beat_next = beat_reg + 2'd1;
                end
            end
            TURN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        resp_next = (state_next == RBURST) || (state_next == WBURST);
        if (state_next == RBURST) begin
            burst_next = mem[{idx_next, beat_next}];
        end
    end

    // State, counters and registered outputs; reset drops any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            beat_reg  <= 2'd0;
            idx_reg   <= '0;
            op_wr_reg <= 1'b0;
            err_reg   <= 1'b0;
            resp_reg  <= 1'b0;
            burst_reg <= 64'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            beat_reg  <= beat_next;
            idx_reg   <= idx_next;
            op_wr_reg <= op_wr_next;
            err_reg   <= err_next;
            resp_reg  <= resp_next;
            burst_reg <= burst_next;
        end
    end

    // Commit one write beat at the end of each write response cycle.
    always_ff @(posedge clk) begin
        if (state_reg == WBURST) begin
            mem[{idx_reg, beat_reg}] <= burst_i;
        end
    end

    assign burst_o        = burst_reg;
    assign resp_o         = resp_reg;
    assign protocol_err_o = err_reg;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder using a line model and a beat scoreboard.
module tb_burst_mem_responder;

    localparam int IDX_W   = 8;
    localparam int LATENCY = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address_i = 32'd0;
    logic        read_i = 1'b0;
    logic        write_i = 1'b0;
    logic [63:0] burst_i = 64'd0;
    logic [63:0] burst_o;
    logic        resp_o;
    logic        protocol_err_o;

    int total = 0;
    int bad = 0;
    int last_lat = 0;

    logic [255:0] ref_mem [int];
    logic [63:0]  exp_q [$];

    burst_mem_responder #(.IDX_W(IDX_W), .LATENCY(LATENCY)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address_i      (address_i),
        .read_i         (read_i),
        .write_i        (write_i),
        .burst_i        (burst_i),
        .burst_o        (burst_o),
        .resp_o         (resp_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    function automatic int line_idx(input logic [31:0] addr);
        return int'(addr[5+IDX_W-1:5]);
    endfunction

    function automatic logic [255:0] make_line(input logic [63:0] base);
        logic [255:0] l;
        for (int b = 0; b < 4; b++) l[64*b +: 64] = base + 64'(b);
        return l;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                             input logic both, input string tag);
        int n;
        @(negedge clk);
        address_i = addr;
        write_i   = 1'b1;
        read_i    = both;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_o && n < 40);
        total++;
        if (!resp_o) begin
            bad++;
            $display("FAIL %s_wr_timeout resp_o=%0b required=1", tag, resp_o);
            write_i = 1'b0;
            read_i  = 1'b0;
            return;
        end
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            burst_i = line[64*b +: 64];
            total++;
            if (resp_o !== 1'b1) begin
                bad++;
                $display("FAIL %s_wr_beat%0d resp_o=%0b required=1", tag, b, resp_o);
            end
        end
        @(negedge clk);
        write_i = 1'b0;
        read_i  = 1'b0;
        total++;
        if (resp_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_wr_end resp_o=%0b required=0", tag, resp_o);
        end
        ref_mem[line_idx(addr)] = line;
        $display("write %s idx=%0d line=%h", tag, line_idx(addr), line);
        @(negedge clk);
    endtask

    task automatic run_read(input logic [31:0] addr, input string tag);
        int n;
        logic [255:0] l;
        logic [63:0]  exp;
        l = ref_mem[line_idx(addr)];
        for (int b = 0; b < 4; b++) exp_q.push_back(l[64*b +: 64]);
        @(negedge clk);
        address_i = addr;
        read_i    = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!resp_o && burst_o !== 64'd0) begin
                bad++;
                $display("FAIL %s_idle_data burst_o=%h required=0", tag, burst_o);
            end
        end while (!resp_o && n < 40);
        last_lat = n;
        total++;
        if (!resp_o) begin
            bad++;
            $display("FAIL %s_rd_timeout resp_o=%0b required=1", tag, resp_o);
            read_i = 1'b0;
            exp_q.delete();
            return;
        end
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            exp = exp_q.pop_front();
            total++;
            if (resp_o !== 1'b1 || burst_o !== exp) begin
                bad++;
                $display("FAIL %s_rd_beat%0d resp_o=%0b burst_o=%h required resp=1 data=%h",
                         tag, b, resp_o, burst_o, exp);
            end
        end
        read_i = 1'b0;
        @(negedge clk);
        total++;
        if (resp_o !== 1'b0 || burst_o !== 64'd0) begin
            bad++;
            $display("FAIL %s_rd_end resp_o=%0b burst_o=%h required 0/0", tag, resp_o, burst_o);
        end
        $display("read %s idx=%0d latency_negedges=%0d", tag, line_idx(addr), last_lat);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (resp_o !== 1'b0 || burst_o !== 64'd0 || protocol_err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state resp=%0b burst=%h err=%0b required 0/0/0",
                     resp_o, burst_o, protocol_err_o);
        end
        reset_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_write_read();
        run_write(32'h0000_0060, make_line(64'hAAAA_0000_0000_0000), 1'b0, "wr_idx3");
        run_read(32'h0000_0060, "rd_idx3");
        run_write(32'h0000_1FE0, make_line(64'h5555_1234_0000_0000), 1'b0, "wr_idx255");
        run_read(32'h0000_1FE0, "rd_idx255");
        total++;
        if (protocol_err_o !== 1'b0) begin
            bad++;
            $display("FAIL clean_err protocol_err_o=%0b required=0", protocol_err_o);
        end
    endtask

    task automatic test_latency();
        run_read(32'h0000_0060, "lat");
        total++;
        if (last_lat !== LATENCY + 1) begin
            bad++;
            $display("FAIL latency negedges=%0d required=%0d", last_lat, LATENCY + 1);
        end
    endtask

    task automatic test_alias();
        run_write(32'h0000_0060, make_line(64'hBEEF_0000_0000_0010), 1'b0, "alias_wr");
        run_read(32'h0000_2060, "alias_rd");
    endtask

    task automatic test_abort();
        int pulses;
        pulse_reset();
        total++;
        if (protocol_err_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_pre_err protocol_err_o=%0b required=0", protocol_err_o);
        end
        address_i = 32'h0000_0060;
        read_i    = 1'b1;
        repeat (2) @(negedge clk);
        read_i = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_o) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_no_resp resp_cycles=%0d required=0", pulses);
        end
        total++;
        if (protocol_err_o !== 1'b1) begin
            bad++;
            $display("FAIL abort_err protocol_err_o=%0b required=1", protocol_err_o);
        end
        $display("abort read dropped in WAIT err=%0b", protocol_err_o);
        run_read(32'h0000_0060, "after_abort");
    endtask

    task automatic test_both();
        pulse_reset();
        run_write(32'h0000_00E0, make_line(64'hC0C0_0000_0000_0700), 1'b1, "both");
        total++;
        if (protocol_err_o !== 1'b1) begin
            bad++;
            $display("FAIL both_err protocol_err_o=%0b required=1", protocol_err_o);
        end
        run_read(32'h0000_00E0, "both_rd");
        run_read(32'h0000_0060, "both_rd2");
        total++;
        if (protocol_err_o !== 1'b1) begin
            bad++;
            $display("FAIL both_sticky protocol_err_o=%0b required=1", protocol_err_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [255:0] old_l;
        logic [255:0] new_l;
        int n;
        run_write(32'h0000_00A0, make_line(64'h0DD0_0000_0000_0500), 1'b0, "mid_old");
        old_l = ref_mem[5];
        new_l = make_line(64'h1EE1_0000_0000_0500);
        @(negedge clk);
        address_i = 32'h0000_00A0;
        write_i   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_o && n < 40);
        total++;
        if (!resp_o) begin
            bad++;
            $display("FAIL mid_timeout resp_o=%0b required=1", resp_o);
        end
        burst_i = new_l[63:0];
        @(negedge clk);
        burst_i = new_l[127:64];
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (resp_o !== 1'b0 || burst_o !== 64'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs resp_o=%0b burst_o=%h required 0/0", resp_o, burst_o);
        end
        write_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        ref_mem[5] = {old_l[255:128], new_l[127:0]};
        $display("reset mid write burst after 2 beats");
        run_read(32'h0000_00A0, "mid_rd");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_alias();
        test_abort();
        test_both();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
